// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side controller for the dual-clock FIFO. It runs in the FIFO read clock
// domain. A start command pops exactly burst_len_i words from the FIFO. The
// FIFO's one-cycle read latency is hidden behind a 2-entry skid buffer, and the
// words are presented as a valid/ready stream with a last-word flag.
//
// Ports
//   clk_b_i       FIFO read clock (only clock of this block)
//   rst_i         synchronous active-high reset
//   start_i       command strobe, sampled in IDLE only
//   burst_len_i   words to read, sampled with start_i (0 = ignored)
//   abort_i       terminate the current burst, sampled in READ only
//   fifo_empty_i  FIFO empty flag
//   fifo_dout_i   FIFO read data, valid the cycle after fifo_ren_o
//   fifo_ren_o    FIFO read enable
//   m_data_o      stream data
//   m_valid_o     stream valid
//   m_ready_i     stream ready
//   m_last_o      marks the final word of the burst
//   busy_o        high whenever not IDLE
//   done_o        one-cycle pulse at burst end
//   aborted_o     qualifies done_o: burst ended by abort
module fifo_burst_reader #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 10
) (
    input  logic              clk_b_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    input  logic              abort_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_dout_i,
    output logic              fifo_ren_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;   // buffer head
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        cnt_mid;
    logic              rd_pend_q;
    logic              aborted_q, aborted_d;
    logic              pop, push;
    logic [2:0]        occ;

    // Stream side and read issue
    always_comb begin
        m_valid_o = (state_q == S_READ) && (cnt_q != 2'd0);
        m_data_o  = buf0_q;
        pop       = m_valid_o && m_ready_i;
        m_last_o  = m_valid_o && (out_cnt_q == len_q - LEN_W'(1));
        // Words landing while draining are discarded.
        push      = rd_pend_q && (state_q == S_READ);
        // Occupancy after this cycle's pop, counting the word still in flight.
        // pop implies cnt_q >= 1, so this never underflows.
        occ       = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        // Abort suppresses issue in its own cycle so unpopped words stay in
        // the FIFO and the drain never has to wait on a fresh read.
        fifo_ren_o = (state_q == S_READ) && !abort_i && !fifo_empty_i &&
                     (issued_q < len_q) && (occ < 3'd2);
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_DONE);
        aborted_o = (state_q == S_DONE) && aborted_q;
    end

    // Next state, counters and skid buffer
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        aborted_d = aborted_q;
        issued_d  = issued_q + LEN_W'(fifo_ren_o);
        out_cnt_d = out_cnt_q + LEN_W'(pop);
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        cnt_mid   = cnt_q;

        // Pop shifts the tail to the head; push then fills the first free slot.
        if (pop) begin
            buf0_d  = buf1_q;
            cnt_mid = cnt_q - 2'd1;
        end
        cnt_d = cnt_mid;
        if (push) begin
            if (cnt_mid == 2'd0) buf0_d = fifo_dout_i;
            else                 buf1_d = fifo_dout_i;
            cnt_d = cnt_mid + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && (burst_len_i != '0)) begin
                    state_d   = S_READ;
                    len_d     = burst_len_i;
                    issued_d  = '0;
                    out_cnt_d = '0;
                    cnt_d     = 2'd0;
                    aborted_d = 1'b0;
                end
            end
            S_READ: begin
                // Abort wins over a coincident last-word handshake.
                if (abort_i) begin
                    state_d   = S_DRAIN;
                    aborted_d = 1'b1;
                    cnt_d     = 2'd0;
                end else if (pop && m_last_o) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (!rd_pend_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_b_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            out_cnt_q <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            cnt_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            out_cnt_q <= out_cnt_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= fifo_ren_o;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the team's dual-clock FIFO, running entirely in the FIFO's read clock domain. On a start command it pops exactly `burst_len` words through the FIFO read port (`ren_b`/`dout_b`/`empty`) and hides the FIFO's one-cycle read latency behind a 2-entry skid buffer. Words are presented as a valid/ready stream with a last-word flag. It sits between the FIFO and any downstream consumer (packetizer, DMA, serializer) that needs bounded bursts with backpressure.

## Interface
- `DATA_W`, 16: word width; equals the FIFO's `FIFO_WIDTH`.
- `LEN_W`, 10: burst length counter width; maximum burst is 2^LEN_W−1 words.

- `clk_b`  in  1  FIFO read clock; the single clock of this block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `burst_len`  in  LEN_W  words to read; sampled with `start`.
- `abort`  in  1  terminate the current burst; sampled in READ only.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_dout`  in  DATA_W  FIFO `dout_b`.
- `fifo_ren`  out  1  FIFO `ren_b`.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  high with the final word of the burst.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at burst end.
- `aborted`  out  1  qualifies `done`: burst ended by `abort`.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE → READ: `start`=1 and `burst_len`≠0. Latch `burst_len`. Clear the issued counter, output counter, and buffer. `start` with `burst_len`=0 is ignored and produces no `done`.
- READ: `fifo_ren` = !`fifo_empty` && issued < len && (buf_cnt + rd_pend − pop) < 2. Here pop = `m_valid` && `m_ready`, and rd_pend = `fifo_ren` registered. `fifo_ren` is never high while `fifo_empty`=1.
- When rd_pend=1, `fifo_dout` is written into the skid buffer on that edge.
- `m_data`/`m_valid` come from the buffer head. The buffer is FIFO-ordered, depth 2. Push and pop in the same cycle are legal.
- `m_last` = `m_valid` && (output counter == len−1).
- READ → DONE: on the handshake of the last word.
- READ → DRAIN: on `abort`=1.
- DRAIN:
  - `fifo_ren`=0 and `m_valid`=0.
  - The buffer is cleared on entry.
  - Any pending read word is discarded when it lands.
  - DRAIN → DONE when rd_pend=0.
- DONE: `done`=1 for this single cycle; `aborted`=1 if entered from DRAIN. Next state is IDLE.
- The issued and output counters are LEN_W wide and never wrap. Issue stops at len.
- Words already popped from the FIFO before an abort are lost. Words not yet popped remain in the FIFO.

## Timing
- Reset values: `fifo_ren`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0, `aborted`=0, state IDLE, buffer empty, rd_pend=0.
- Reset mid-burst returns to IDLE next cycle. No `done` pulse is produced, and any in-flight word is dropped.
- `start` at cycle 0 → READ at cycle 1 → earliest `fifo_ren` at cycle 1.
- `fifo_ren` at cycle N → `fifo_dout` valid at N+1 → `m_valid` at N+2.
- Throughput: 1 word/cycle when `fifo_empty`=0 and `m_ready`=1 continuously.
- `m_ready` low: `m_data`/`m_valid`/`m_last` hold stable. At most 2 words are buffered, and `fifo_ren` stalls with no word loss.
- Last-word handshake at cycle T → `done` at T+1 → IDLE at T+2. A new `start` is accepted at T+2.
- `abort` at cycle A (READ):
  - DRAIN from A+1, with `m_valid`=0 at A+1.
  - If rd_pend=0 at A+1, `done`/`aborted` at A+2. Otherwise at A+3.
- `abort` coincident with the last-word handshake: abort wins, and `aborted`=1.
- `start` or `abort` outside its sampling state is ignored.
- `fifo_empty` rising mid-burst pauses issue. Buffered words continue to drain.

## Test plan
- FIFO preloaded with 0x0001..0x0008, `burst_len`=8, `m_ready`=1 → `fifo_ren` high cycles 1–8. `m_valid` cycles 3–10 with data 0x0001..0x0008. `m_last` at cycle 10, `done` at 11, `aborted`=0.
- Same preload with `m_ready` toggling 1,0,0,1,… → every word appears exactly once and in order, with data held while stalled. No more than 2 reads outstanding beyond accepted words.
- `burst_len`=4, FIFO holds 2 words, third word written 10 cycles later → `fifo_ren` is never high while `fifo_empty`=1. Burst completes only after the 4th word arrives, with `m_last` on the 4th word.
- `burst_len`=16, `abort` at the cycle of the 5th handshake → `m_valid`=0 next cycle. `done`=`aborted`=1 within 2 cycles. The FIFO keeps its unread words: at least 10 remain.
- `start` with `burst_len`=0 → stays IDLE, `busy`=0, no `done`. `rst` asserted mid-burst → all outputs at reset values next cycle, and a new burst runs correctly after reset.
